// File: rtl/seq_detector_moore_param.sv
// Moore detector for a run-time loadable PAT_LEN-bit serial pattern with
// overlap / non-overlap modes and a saturating match counter.
module seq_detector_moore_param #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               w,
  input  logic               load,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               overlap,
  input  logic               clr_cnt,
  output logic               z,
  output logic [CNT_W-1:0]   match_count,
  output logic               cnt_sat
);

  localparam int SW = $clog2(PAT_LEN + 1);
  localparam int IW = $clog2(PAT_LEN);
  localparam logic [SW-1:0]    FULL    = SW'(PAT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_LEN-1:0] pat_q;
  logic [SW-1:0]      s_q, s_nxt;
  int                 hist_len, idx;
  logic               ok, hbit;

  // The history is the first hist_len pattern bits followed by w; the next
  // state is the longest suffix of that string that is also a pattern prefix.
  always_comb begin
    hist_len = (s_q == FULL && !overlap) ? 0 : int'(s_q);
    s_nxt    = '0;
    ok       = 1'b0;
    hbit     = 1'b0;
    idx      = 0;
    for (int k = 1; k <= PAT_LEN; k++) begin
      if (k <= hist_len + 1) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++) begin
          idx  = hist_len + 1 - k + i;
          hbit = (idx == hist_len) ? w : pat_q[IW'(PAT_LEN - 1 - idx)];
          if (hbit != pat_q[IW'(PAT_LEN - 1 - i)]) ok = 1'b0;
        end
        if (ok) s_nxt = SW'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q       <= '0;
      s_q         <= '0;
      z           <= 1'b0;
      match_count <= '0;
      cnt_sat     <= 1'b0;
    end else if (load) begin
      pat_q       <= pattern;
      s_q         <= '0;
      z           <= 1'b0;
      match_count <= '0;
      cnt_sat     <= 1'b0;
    end else begin
      if (en) begin
        s_q <= s_nxt;
        z   <= (s_nxt == FULL);
      end
      // Clear beats a same-edge increment; counter pins at max, never wraps.
      if (clr_cnt) begin
        match_count <= '0;
        cnt_sat     <= 1'b0;
      end else if (en && s_nxt == FULL && match_count != CNT_MAX) begin
        match_count <= match_count + CNT_W'(1);
        if (match_count == CNT_MAX - CNT_W'(1)) cnt_sat <= 1'b1;
      end
    end
  end

endmodule

// File: doc/seq_detector_moore_param.md
Name: seq_detector_moore_param

Overview:
Parametrised Moore sequence detector and the successor to the two-bit, fixed-pattern W/Zout detector.
- Watches a serial input bit for a PAT_LEN-bit pattern that is loaded at run time.
- Supports overlapping and non-overlapping match modes.
- Counts matches in a saturating counter.
- Sits between the serial input synchroniser and the status/display logic; all outputs are registered (pure Moore).

Parameters:
PAT_LEN, 4, pattern length in bits; legal range 2..16.
CNT_W, 8, width of the match counter; legal range 1..16.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  sample enable; w is consumed only on cycles where en=1.
w  input  1  serial data bit.
load  input  1  pattern load strobe.
pattern  input  PAT_LEN  pattern to detect; bit PAT_LEN-1 is the first bit expected.
overlap  input  1  1 = overlapping matches allowed; 0 = history is cleared after each match.
clr_cnt  input  1  synchronous clear of match_count and cnt_sat.
z  output  1  Moore match flag.
match_count  output  CNT_W  number of matches since reset, load or clr_cnt; saturating.
cnt_sat  output  1  sticky flag, set when match_count is at its maximum value.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=0, z=0, match_count=0, cnt_sat=0.
  - Stored pattern = all zeros.
- State variable:
  - s ranges 0..PAT_LEN and holds the number of pattern prefix bits currently matched.
  - s is the length of the longest suffix of the consumed history that equals a prefix of the stored pattern (KMP-equivalent).
  - State register width is clog2(PAT_LEN+1).
- Moore output: z = (s == PAT_LEN). z depends on the state register only, never combinationally on w.
- Latency: the bit that completes the pattern is sampled at edge k; z=1 during the cycle after edge k.
- en=0: s, z, match_count and cnt_sat all hold; w is ignored.
- Transition when en=1 and load=0, from the current history extended by w:
  - In state PAT_LEN with overlap=1: the history keeps the full matched pattern, so the fallback uses the longest proper border.
  - In state PAT_LEN with overlap=0: the history is treated as empty, so the next s is 1 if w equals pattern[PAT_LEN-1], otherwise 0.
- Counter:
  - match_count increments by 1 on every edge where next s == PAT_LEN, including consecutive matches in overlap mode.
  - At the maximum value (2^CNT_W-1) the counter holds and cnt_sat=1.
  - cnt_sat stays set until reset, load or clr_cnt.
- load=1 (has priority over en):
  - Captures pattern into the stored pattern.
  - Forces s=0, z=0 and clears match_count and cnt_sat.
  - w is not consumed on that edge.
- clr_cnt=1 with en=1: the clear wins over an increment on the same edge; s still advances normally.
- overlap is sampled every cycle. Changing it mid-stream affects only the next transition out of state PAT_LEN.
- Reset asserted mid-stream: all state is cleared immediately, without waiting for a clock edge.
- Reset release: first detection starts from s=0 with the all-zero pattern until a load occurs.
- Width rules: the counter never wraps; all internal indices are sized from PAT_LEN, with no truncation warnings.

Test Plan:
- PAT_LEN=4, load pattern=4'b1011, overlap=1, en=1, w=1,0,1,1,0,1,1 → z high in the cycle after bit 4 and after bit 7; match_count=2.
- Same pattern and stream with overlap=0 → z high only after bit 4; match_count=1.
- pattern=4'b1111, overlap=1, six consecutive 1s → z high for 3 consecutive cycles (after bits 4, 5, 6); match_count=3. Repeat with overlap=0 → z high after bit 4 only; with 8 ones, z high after bits 4 and 8.
- pattern=1011, stream 1,0,1 then en=0 for 5 cycles with w toggling, then en=1 with w=1 → match completes; z=1 one cycle later; no state change during the stall.
- CNT_W=2, pattern=4'b1111, overlap=1, 8 ones → match_count=1,2,3,3,3; cnt_sat=1 from the third match; then clr_cnt=1 → count=0 and cnt_sat=0 on the next edge.
- Mid-stream checks:
  - After 1,0,1, assert rst_n=0 between clock edges → z, state and count are 0 immediately.
  - Then load=1 with pattern=1011 and en=1 on the same edge → w not consumed, s=0.
  - The following 1,0,1,1 → z=1.
